// File: rtl/mix_columns_seq_pkg.sv
// aes_pkg: GF(2^8) constant multipliers, column geometry and FSM state type for the column mixer.
package aes_pkg;
   localparam int COL_W = 32;
   localparam int NCOLS = 4;
   localparam int STATE_W = COL_W * NCOLS;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gf_mul02(input logic [7:0] x);
      return xtime(x);
   endfunction
   function automatic logic [7:0] gf_mul03(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction
   function automatic logic [7:0] gf_mul09(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ x;
   endfunction
   function automatic logic [7:0] gf_mul0b(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
   endfunction
   function automatic logic [7:0] gf_mul0d(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
   endfunction
   function automatic logic [7:0] gf_mul0e(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
   endfunction
endpackage

// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if: input/output valid-ready handshake of the column mixer.
interface mix_columns_seq_if;
   import aes_pkg::*;
   logic in_valid, in_ready, in_inv, out_valid, out_ready, busy;
   logic [STATE_W-1:0] in_state, out_state;
   modport master(output in_valid, in_state, in_inv, out_ready, input in_ready, out_valid, out_state, busy);
   modport slave(input in_valid, in_state, in_inv, out_ready, output in_ready, out_valid, out_state, busy);
endinterface

// File: rtl/mix_columns_seq_word.sv
// mix_column_word: combinational MixColumns/InvMixColumns of one 32-bit column, row 0 in the top byte.
module mix_column_word import aes_pkg::*; #(
   parameter bit INV_EN = 1
) (
   input  logic [COL_W-1:0] col,
   input  logic             inv,
   output logic [COL_W-1:0] mixed
);
   logic [7:0] b [NCOLS];
   for (genvar r = 0; r < NCOLS; r++) begin : g_row
      logic [7:0] f;
      assign b[r] = col[COL_W-1-8*r -: 8];
      assign f = gf_mul02(b[r]) ^ gf_mul03(b[(r+1)%4]) ^ b[(r+2)%4] ^ b[(r+3)%4];
      if (INV_EN) begin : g_inv
         logic [7:0] v;
         assign v = gf_mul0e(b[r]) ^ gf_mul0b(b[(r+1)%4]) ^ gf_mul0d(b[(r+2)%4]) ^ gf_mul09(b[(r+3)%4]);
         assign mixed[COL_W-1-8*r -: 8] = inv ? v : f;
      end else begin : g_fwd
         assign mixed[COL_W-1-8*r -: 8] = f;
      end
   end
   if (!INV_EN) begin : g_no_inv
      logic unused_inv;
      assign unused_inv = inv;
   end
endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES (Inv)MixColumns, COLS_PER_CYCLE columns per clock, result held until accepted.
module mix_columns_seq import aes_pkg::*; #(
   parameter int COLS_PER_CYCLE = 1,
   parameter bit INV_EN = 1
) (
   input logic clk,
   input logic rst_n,
   mix_columns_seq_if.slave bus
);
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end
   localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST = 2'(NCOLS - COLS_PER_CYCLE);
   state_t state, state_nx;
   logic [NCOLS-1:0][COL_W-1:0] w;
   logic [COL_W-1:0] mixed [COLS_PER_CYCLE];
   logic m, take, out_valid, busy;
   logic [1:0] k;
   assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
   assign take = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy = busy;
   assign bus.out_state = w;
   // k is a multiple of COLS_PER_CYCLE, so k+c never wraps inside one step
   for (genvar c = 0; c < COLS_PER_CYCLE; c++) begin : g_col
      logic [1:0] idx;
      assign idx = k + 2'(c);
      mix_column_word #(.INV_EN(INV_EN)) u_mix (.col(w[idx]), .inv(m), .mixed(mixed[c]));
   end
   always_comb begin
      state_nx = take ? CALC :
                 state == CALC ? (k == LAST ? DONE : CALC) :
                 (state == DONE && bus.out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         w <= '0;
         m <= 1'b0;
         k <= '0;
         out_valid <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_nx;
         out_valid <= state_nx == DONE;
         busy <= state_nx == CALC;
         if (take) begin
            w <= bus.in_state;
            m <= INV_EN && bus.in_inv;
            k <= '0;
         end else if (state == CALC) begin
            for (int i = 0; i < COLS_PER_CYCLE; i++) w[k + 2'(i)] <= mixed[i];
            k <= k + STEP;
         end
      end
   end
endmodule
